// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcode, funct7 and ALU operation encodings
package rv32i_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
endpackage

// File: rtl/control_unit_alu_decoder.sv
// alu_decoder: combinational ALU op selection and funct/opcode legality check
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       funct_ok
);
  logic       base, alt;
  logic [3:0] arith;
  assign base = funct7 == F7_BASE;
  assign alt  = funct7 == F7_ALT;
  always_comb begin
    arith = funct3 == 3'b000 ? ((opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD) :
            funct3 == 3'b001 ? ALU_SLL :
            funct3 == 3'b010 ? ALU_SLT :
            funct3 == 3'b011 ? ALU_SLTU :
            funct3 == 3'b100 ? ALU_XOR :
            funct3 == 3'b101 ? (funct7[5] ? ALU_SRA : ALU_SRL) :
            funct3 == 3'b110 ? ALU_OR : ALU_AND;
  end
  always_comb begin
    alu_ctrl = ALU_ADD;
    funct_ok = 1'b0;
    case (opcode)
      OP_R: begin
        alu_ctrl = arith;
        funct_ok = base || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_IMM: begin
        alu_ctrl = arith;
        funct_ok = funct3 == 3'b001 ? base : funct3 == 3'b101 ? (base || alt) : 1'b1;
      end
      OP_LOAD:   funct_ok = funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111;
      OP_STORE:  funct_ok = funct3 <= 3'b010;
      OP_BRANCH: begin
        alu_ctrl = funct3[2:1] == 2'b00 ? ALU_SUB : funct3[1] ? ALU_SLTU : ALU_SLT;
        funct_ok = funct3[2:1] != 2'b01;
      end
      OP_JAL:    funct_ok = 1'b1;
      OP_JALR:   funct_ok = funct3 == 3'b000;
      OP_LUI: begin
        alu_ctrl = ALU_PASSB;
        funct_ok = 1'b1;
      end
      OP_AUIPC:  funct_ok = 1'b1;
      default:   funct_ok = 1'b0;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: registered RV32I main decoder producing datapath strobes and ALU op
module control_unit
  import rv32i_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  branch_taken,
  output logic                  imm_select,
  output logic                  jump,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal
);
  logic [6:0] ctl;
  logic [3:0] alu;
  logic       ok;
  alu_decoder u_alu_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (alu),
    .funct_ok (ok)
  );
  always_comb begin
    ctl = 7'b0000000;
    case (opcode)
      OP_R:                     ctl = 7'b1000000;
      OP_IMM, OP_LUI, OP_AUIPC: ctl = 7'b1000010;
      OP_LOAD:                  ctl = 7'b1101010;
      OP_STORE:                 ctl = 7'b0010010;
      OP_BRANCH:                ctl = 7'b0000100;
      OP_JAL, OP_JALR:          ctl = 7'b1000011;
      default:                  ctl = 7'b0000000;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {reg_write, mem_read, mem_write, mem_to_reg, branch_taken, imm_select, jump} <= 7'b0;
      alu_ctrl <= '0;
      illegal  <= 1'b0;
    end else begin
      {reg_write, mem_read, mem_write, mem_to_reg, branch_taken, imm_select, jump} <= ok ? ctl : 7'b0;
      alu_ctrl <= ok ? ALU_CTRL_W'(alu) : '0;
      illegal  <= !ok;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench with directed decode vectors
module tb_control_unit;
  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic [3:0] alu;
    logic       ill;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic       reg_write, mem_read, mem_write, mem_to_reg, branch_taken, imm_select, jump, illegal;
  logic [3:0] alu_ctrl;
  exp_t       q[$];
  exp_t       cur;
  logic       have = 1'b0;
  int         errors = 0;
  int         checks = 0;
  control_unit #(.ALU_CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch_taken(branch_taken), .imm_select(imm_select),
    .jump(jump), .alu_ctrl(alu_ctrl), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic compare(input string tag, input exp_t e);
    logic [6:0] a;
    a = {reg_write, mem_read, mem_write, mem_to_reg, branch_taken, imm_select, jump};
    checks++;
    if (a !== e.ctl || alu_ctrl !== e.alu || illegal !== e.ill) begin
      errors++;
      $display("FAIL %s %s: got ctl=%b alu=%b ill=%b, want ctl=%b alu=%b ill=%b",
               e.name, tag, a, alu_ctrl, illegal, e.ctl, e.alu, e.ill);
    end
  endtask
  task automatic apply(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input string name, input logic [6:0] ctl,
                       input logic [3:0] alu, input logic ill);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; opcode = op; funct3 = f3; funct7 = f7;
    e.name = name; e.ctl = ctl; e.alu = alu; e.ill = ill;
    q.push_back(e);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        cur = q.pop_front();
        have = 1'b1;
        compare("edge", cur);
      end else have = 1'b0;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (have) compare("hold", cur);
    end
  end
  initial begin
    apply(1, 7'b0110011, 3'b000, 7'b0000000, "rst0", 7'b0000000, 4'b0000, 0);
    apply(1, 7'b0110011, 3'b000, 7'b0000000, "rst1", 7'b0000000, 4'b0000, 0);
    apply(0, 7'b0110011, 3'b000, 7'b0000000, "add", 7'b1000000, 4'b0000, 0);
    apply(0, 7'b0110011, 3'b000, 7'b0100000, "sub", 7'b1000000, 4'b0001, 0);
    apply(0, 7'b0110011, 3'b101, 7'b0100000, "sra", 7'b1000000, 4'b0111, 0);
    apply(0, 7'b0110011, 3'b111, 7'b0000000, "and", 7'b1000000, 4'b1001, 0);
    apply(0, 7'b0110011, 3'b001, 7'b0100000, "sll_alt", 7'b0000000, 4'b0000, 1);
    apply(0, 7'b0110011, 3'b000, 7'b1111111, "r_badf7", 7'b0000000, 4'b0000, 1);
    apply(0, 7'b0010011, 3'b000, 7'b0000000, "addi", 7'b1000010, 4'b0000, 0);
    apply(0, 7'b0010011, 3'b000, 7'b0100000, "addi_f7", 7'b1000010, 4'b0000, 0);
    apply(0, 7'b0010011, 3'b101, 7'b0100000, "srai", 7'b1000010, 4'b0111, 0);
    apply(0, 7'b0010011, 3'b101, 7'b0000000, "srli", 7'b1000010, 4'b0110, 0);
    apply(0, 7'b0010011, 3'b001, 7'b0100000, "slli_bad", 7'b0000000, 4'b0000, 1);
    apply(0, 7'b0010011, 3'b111, 7'b1111111, "andi_f7", 7'b1000010, 4'b1001, 0);
    apply(0, 7'b0010011, 3'b011, 7'b0000000, "sltiu", 7'b1000010, 4'b0100, 0);
    apply(0, 7'b0000011, 3'b010, 7'b0000000, "lw", 7'b1101010, 4'b0000, 0);
    apply(0, 7'b0000011, 3'b011, 7'b0000000, "load_bad", 7'b0000000, 4'b0000, 1);
    apply(0, 7'b0100011, 3'b010, 7'b0000000, "sw", 7'b0010010, 4'b0000, 0);
    apply(0, 7'b0100011, 3'b011, 7'b0000000, "store_bad", 7'b0000000, 4'b0000, 1);
    apply(0, 7'b1100011, 3'b000, 7'b0000000, "beq", 7'b0000100, 4'b0001, 0);
    apply(0, 7'b1100011, 3'b100, 7'b0000000, "blt", 7'b0000100, 4'b0011, 0);
    apply(0, 7'b1100011, 3'b111, 7'b0000000, "bgeu", 7'b0000100, 4'b0100, 0);
    apply(0, 7'b1100011, 3'b010, 7'b0000000, "br_bad", 7'b0000000, 4'b0000, 1);
    apply(0, 7'b1101111, 3'b111, 7'b1111111, "jal", 7'b1000011, 4'b0000, 0);
    apply(0, 7'b1100111, 3'b000, 7'b0000000, "jalr", 7'b1000011, 4'b0000, 0);
    apply(0, 7'b1100111, 3'b001, 7'b0000000, "jalr_bad", 7'b0000000, 4'b0000, 1);
    apply(0, 7'b0110111, 3'b000, 7'b0000000, "lui", 7'b1000010, 4'b1010, 0);
    apply(0, 7'b0010111, 3'b000, 7'b0000000, "auipc", 7'b1000010, 4'b0000, 0);
    apply(0, 7'b1111111, 3'b111, 7'b1111111, "unknown", 7'b0000000, 4'b0000, 1);
    apply(0, 7'b0000011, 3'b010, 7'b0000000, "lw2", 7'b1101010, 4'b0000, 0);
    apply(1, 7'b0000011, 3'b010, 7'b0000000, "rst_after_lw", 7'b0000000, 4'b0000, 0);
    apply(0, 7'b0110011, 3'b000, 7'b0100000, "sub2", 7'b1000000, 4'b0001, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end
endmodule
